// File: rtl/sp_multicycle_core_if.sv
// Instruction-fetch and data-memory handshake bundle for sp_multicycle_core.
// master = core side, slave = instruction source / data memory side.
interface sp_multicycle_core_if #(
  parameter int DATA_W = 32,
  parameter int MEM_AW = 12
);
  logic              in_valid;
  logic [31:0]       inst;
  logic              out_valid;
  logic [31:0]       inst_addr;
  logic              err;
  logic              mem_req;
  logic              mem_we;
  logic [MEM_AW-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;

  modport master (
    input  in_valid, inst, mem_rdata, mem_ready,
    output out_valid, inst_addr, err, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output in_valid, inst, mem_rdata, mem_ready,
    input  out_valid, inst_addr, err, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/sp_multicycle_core.sv
// Multi-cycle SP core: IDLE -> EXEC -> (MEM) -> DONE, one instruction per in_valid handshake,
// with a variable-latency data-memory port guarded by a timeout.
module sp_multicycle_core #(
  parameter int DATA_W      = 32,
  parameter int MEM_AW      = 12,
  parameter int MEM_TIMEOUT = 6,
  parameter int R0_ZERO     = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  sp_multicycle_core_if.master  bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_MEM  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [2:0] TMO_LAST = 3'(MEM_TIMEOUT - 1);

  logic [1:0]        r_state;
  logic [31:0]       r_inst;
  logic [31:0]       r_pc;
  logic [DATA_W-1:0] r_regs [32];
  logic              r_out_valid;
  logic              r_err;
  logic              r_mem_req;
  logic              r_mem_we;
  logic [MEM_AW-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic [2:0]        r_tcnt;

  logic [5:0]  w_op;
  logic [5:0]  w_fn;
  logic [4:0]  w_rs;
  logic [4:0]  w_rt;
  logic [4:0]  w_rd;
  logic [4:0]  w_sh;
  logic [15:0] w_imm;
  logic [25:0] w_tgt;

  assign w_op  = r_inst[31:26];
  assign w_rs  = r_inst[25:21];
  assign w_rt  = r_inst[20:16];
  assign w_rd  = r_inst[15:11];
  assign w_sh  = r_inst[10:6];
  assign w_fn  = r_inst[5:0];
  assign w_imm = r_inst[15:0];
  assign w_tgt = r_inst[25:0];

  logic [DATA_W-1:0] w_rs_val;
  logic [DATA_W-1:0] w_rt_val;
  logic [DATA_W-1:0] w_sext;
  logic [DATA_W-1:0] w_zext;
  logic [31:0]       w_pc4;
  logic [31:0]       w_boff;
  logic [MEM_AW-1:0] w_ea;
  logic              w_slt;

  assign w_rs_val = (R0_ZERO != 0 && w_rs == 5'd0) ? '0 : r_regs[w_rs];
  assign w_rt_val = (R0_ZERO != 0 && w_rt == 5'd0) ? '0 : r_regs[w_rt];
  assign w_sext   = DATA_W'($signed(w_imm));
  assign w_zext   = DATA_W'(w_imm);
  assign w_pc4    = r_pc + 32'd4;
  assign w_boff   = {{14{w_imm[15]}}, w_imm, 2'b00};
  // Only the low MEM_AW bits of the effective address ever reach the port.
  assign w_ea     = w_rs_val[MEM_AW-1:0] + w_sext[MEM_AW-1:0];
  assign w_slt    = $signed(w_rs_val) < $signed(w_rt_val);

  logic              w_wen;
  logic [4:0]        w_wsel;
  logic [DATA_W-1:0] w_wdata;
  logic [31:0]       w_npc;
  logic              w_illegal;
  logic              w_is_mem;
  logic              w_is_store;

  always_comb begin
    w_wen      = 1'b0;
    w_wsel     = w_rt;
    w_wdata    = '0;
    w_npc      = w_pc4;
    w_illegal  = 1'b0;
    w_is_mem   = 1'b0;
    w_is_store = 1'b0;
    case (w_op)
      6'd0: begin
        w_wsel = w_rd;
        w_wen  = 1'b1;
        case (w_fn)
          6'd0: w_wdata = w_rs_val & w_rt_val;
          6'd1: w_wdata = w_rs_val | w_rt_val;
          6'd2: w_wdata = w_rs_val + w_rt_val;
          6'd3: w_wdata = w_rs_val - w_rt_val;
          6'd4: w_wdata = DATA_W'(w_slt);
          6'd5: w_wdata = w_rs_val << w_sh;
          6'd6: w_wdata = ~(w_rs_val | w_rt_val);
          6'd7: begin
            w_wen = 1'b0;
            w_npc = 32'(w_rs_val);
          end
          default: begin
            w_wen     = 1'b0;
            w_illegal = 1'b1;
          end
        endcase
      end
      6'd1: begin w_wen = 1'b1; w_wdata = w_rs_val & w_zext; end
      6'd2: begin w_wen = 1'b1; w_wdata = w_rs_val | w_zext; end
      6'd3: begin w_wen = 1'b1; w_wdata = w_rs_val + w_sext; end
      6'd4: begin w_wen = 1'b1; w_wdata = w_rs_val - w_sext; end
      6'd5: w_is_mem = 1'b1;
      6'd6: begin w_is_mem = 1'b1; w_is_store = 1'b1; end
      6'd7: if (w_rs_val == w_rt_val) w_npc = w_pc4 + w_boff;
      6'd8: if (w_rs_val != w_rt_val) w_npc = w_pc4 + w_boff;
      6'd9: begin w_wen = 1'b1; w_wdata = w_zext << 16; end
      6'd10: w_npc = {r_pc[31:28], w_tgt, 2'b00};
      6'd11: begin
        // Link value and jump target both derive from the old PC.
        w_wen   = 1'b1;
        w_wsel  = 5'd31;
        w_wdata = DATA_W'(w_pc4);
        w_npc   = {r_pc[31:28], w_tgt, 2'b00};
      end
      default: w_illegal = 1'b1;
    endcase
  end

  logic w_rf_we;
  logic w_ld_we;

  assign w_rf_we = w_wen && !(R0_ZERO != 0 && w_wsel == 5'd0);
  assign w_ld_we = !(R0_ZERO != 0 && w_rt == 5'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_inst      <= '0;
      r_pc        <= '0;
      r_out_valid <= 1'b0;
      r_err       <= 1'b0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_tcnt      <= '0;
      for (int unsigned i = 0; i < 32; i++) r_regs[i] <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.in_valid) begin
            r_inst  <= bus.inst;
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (w_is_mem) begin
            r_mem_req   <= 1'b1;
            r_mem_we    <= w_is_store;
            r_mem_addr  <= w_ea;
            r_mem_wdata <= w_rt_val;
            r_tcnt      <= '0;
            r_state     <= S_MEM;
          end else begin
            if (w_rf_we) r_regs[w_wsel] <= w_wdata;
            r_pc        <= w_npc;
            r_err       <= w_illegal;
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end
        end
        S_MEM: begin
          // mem_ready is checked before the timeout so a late reply in the last cycle still commits.
          if (bus.mem_ready) begin
            if (!r_mem_we && w_ld_we) r_regs[w_rt] <= bus.mem_rdata;
            r_mem_req   <= 1'b0;
            r_pc        <= w_pc4;
            r_err       <= 1'b0;
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end else if (r_tcnt == TMO_LAST) begin
            r_mem_req   <= 1'b0;
            r_pc        <= w_pc4;
            r_err       <= 1'b1;
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end else begin
            r_tcnt <= r_tcnt + 3'd1;
          end
        end
        S_DONE: begin
          r_out_valid <= 1'b0;
          r_err       <= 1'b0;
          r_state     <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.inst_addr = r_pc;
  assign bus.err       = r_err;
  assign bus.mem_req   = r_mem_req;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_sp_multicycle_core.sv
// Bench for sp_multicycle_core: directed vector table, reset/abort sequences and
// randomized instructions checked against an ISA-level reference model.
module tb_sp_multicycle_core;

  localparam int DW  = 32;
  localparam int AW  = 12;
  localparam int TMO = 6;
  localparam int R0Z = 0;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sp_multicycle_core_if #(.DATA_W(DW), .MEM_AW(AW)) bus ();

  sp_multicycle_core #(
    .DATA_W(DW), .MEM_AW(AW), .MEM_TIMEOUT(TMO), .R0_ZERO(R0Z)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic        err;
    logic [31:0] pc;
    int          lat;
    bit          mem;
    logic        we;
    logic [11:0] addr;
    logic [31:0] wd;
    int          reqc;
    bit          stable;
    bit          finished;
    bit          single;
  } obs_t;

  typedef struct {
    logic [31:0] inst;
    int          d;
    bit          pulse;
    logic        err;
    logic [31:0] pc;
    int          lat;
    bit          mem;
    logic        we;
    logic [11:0] addr;
    logic [31:0] wd;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] m_regs [32];
  logic [31:0] m_pc;
  logic [31:0] m_mem  [4096];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rv(input logic [4:0] i);
    return (R0Z != 0 && i == 5'd0) ? 32'd0 : m_regs[i];
  endfunction

  task automatic wr(input logic [4:0] i, input logic [31:0] v);
    if (!(R0Z != 0 && i == 5'd0)) m_regs[i] = v;
  endtask

  // ISA-level reference: architectural effect plus expected handshake timing.
  task automatic model_step(input logic [31:0] ins, input int d, output obs_t x);
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [4:0]  rs, rt, rd, sh;
    logic [31:0] a, b, se, ze, npc, ea;
    bit          tmo;
    op = ins[31:26]; rs = ins[25:21]; rt = ins[20:16]; rd = ins[15:11];
    sh = ins[10:6];  fn = ins[5:0];
    a  = rv(rs); b = rv(rt);
    se = {{16{ins[15]}}, ins[15:0]};
    ze = {16'd0, ins[15:0]};
    npc = m_pc + 32'd4;
    x.err = 1'b0; x.lat = 2; x.mem = 1'b0; x.we = 1'b0; x.addr = '0; x.wd = '0;
    x.reqc = 0; x.stable = 1'b1; x.finished = 1'b1; x.single = 1'b1;
    case (op)
      6'd0: case (fn)
        6'd0: wr(rd, a & b);
        6'd1: wr(rd, a | b);
        6'd2: wr(rd, a + b);
        6'd3: wr(rd, a - b);
        6'd4: wr(rd, ($signed(a) < $signed(b)) ? 32'd1 : 32'd0);
        6'd5: wr(rd, a << sh);
        6'd6: wr(rd, ~(a | b));
        6'd7: npc = a;
        default: x.err = 1'b1;
      endcase
      6'd1: wr(rt, a & ze);
      6'd2: wr(rt, a | ze);
      6'd3: wr(rt, a + se);
      6'd4: wr(rt, a - se);
      6'd5, 6'd6: begin
        ea     = a + se;
        tmo    = (d >= TMO);
        x.mem  = 1'b1;
        x.we   = (op == 6'd6);
        x.addr = ea[11:0];
        x.wd   = b;
        x.reqc = tmo ? TMO : d + 1;
        x.lat  = tmo ? 2 + TMO : 3 + d;
        x.err  = tmo;
        if (!tmo) begin
          if (op == 6'd6) m_mem[ea[11:0]] = b;
          else            wr(rt, m_mem[ea[11:0]]);
        end
      end
      6'd7: if (a == b) npc = m_pc + 32'd4 + (se << 2);
      6'd8: if (a != b) npc = m_pc + 32'd4 + (se << 2);
      6'd9: wr(rt, {ins[15:0], 16'd0});
      6'd10: npc = {m_pc[31:28], ins[25:0], 2'b00};
      6'd11: begin
        wr(5'd31, m_pc + 32'd4);
        npc = {m_pc[31:28], ins[25:0], 2'b00};
      end
      default: x.err = 1'b1;
    endcase
    m_pc = npc;
    x.pc = npc;
  endtask

  // Issue one instruction, act as data memory replying on the d-th request cycle, observe retire.
  task automatic run_inst(input logic [31:0] ins, input int d, input bit pulse, output obs_t o);
    int mcnt;
    mcnt = 0;
    o.err = 1'b0; o.pc = '0; o.lat = 0; o.mem = 1'b0; o.we = 1'b0; o.addr = '0; o.wd = '0;
    o.reqc = 0; o.stable = 1'b1; o.finished = 1'b0; o.single = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.inst     = ins;
    @(posedge clk);
    o.lat = 1;
    #1;
    bus.in_valid = pulse;
    bus.inst     = pulse ? 32'h0C1F0001 : $urandom;
    while (o.lat < 40 && !o.finished) begin
      @(posedge clk);
      o.lat++;
      #1;
      bus.in_valid  = 1'b0;
      bus.mem_ready = 1'b0;
      if (bus.out_valid) begin
        o.finished = 1'b1;
        o.err      = bus.err;
        o.pc       = bus.inst_addr;
      end else if (bus.mem_req) begin
        if (!o.mem) begin
          o.mem = 1'b1; o.we = bus.mem_we; o.addr = bus.mem_addr; o.wd = bus.mem_wdata;
        end else if (o.we !== bus.mem_we || o.addr !== bus.mem_addr || o.wd !== bus.mem_wdata) begin
          o.stable = 1'b0;
        end
        o.reqc++;
        if (mcnt == d) begin
          bus.mem_ready = 1'b1;
          bus.mem_rdata = m_mem[bus.mem_addr];
        end else begin
          bus.mem_rdata = $urandom;
        end
        mcnt++;
      end
    end
    if (o.finished) begin
      repeat (4) begin
        @(posedge clk);
        #1;
        if (bus.out_valid || bus.mem_req) o.single = 1'b0;
      end
    end
  endtask

  task automatic cmp_obs(input string tag, input obs_t a, input obs_t x);
    check({tag, ".retired"}, 32'(a.finished), 32'(x.finished));
    check({tag, ".err"},     32'(a.err),      32'(x.err));
    check({tag, ".pc"},      a.pc,            x.pc);
    check({tag, ".lat"},     32'(a.lat),      32'(x.lat));
    check({tag, ".single"},  32'(a.single),   32'(x.single));
    check({tag, ".mem"},     32'(a.mem),      32'(x.mem));
    check({tag, ".reqc"},    32'(a.reqc),     32'(x.reqc));
    if (x.mem) begin
      check({tag, ".we"},     32'(a.we),     32'(x.we));
      check({tag, ".addr"},   32'(a.addr),   32'(x.addr));
      check({tag, ".wdata"},  a.wd,          x.wd);
      check({tag, ".stable"}, 32'(a.stable), 32'(x.stable));
    end
  endtask

  task automatic exec_one(input logic [31:0] ins, input int d, input bit pulse,
                          output obs_t a, output obs_t x);
    model_step(ins, d, x);
    run_inst(ins, d, pulse, a);
  endtask

  vec_t tbl [20];

  initial begin
    obs_t        a, x, t;
    logic [31:0] ins;
    logic [5:0]  op;
    int          d;
    bit          p;

    tbl[0]  = '{32'h0C01FFFB, 0, 1'b0, 1'b0, 32'h04,  2, 1'b0, 1'b0, 12'h0, 32'h0};
    tbl[1]  = '{32'h00201004, 0, 1'b0, 1'b0, 32'h08,  2, 1'b0, 1'b0, 12'h0, 32'h0};
    tbl[2]  = '{32'h18010003, 0, 1'b0, 1'b0, 32'h0C,  3, 1'b1, 1'b1, 12'h3, 32'hFFFFFFFB};
    tbl[3]  = '{32'h14030003, 2, 1'b0, 1'b0, 32'h10,  5, 1'b1, 1'b0, 12'h3, 32'h0};
    tbl[4]  = '{32'h28000002, 0, 1'b0, 1'b0, 32'h08,  2, 1'b0, 1'b0, 12'h0, 32'h0};
    tbl[5]  = '{32'h2020FFFE, 0, 1'b0, 1'b0, 32'h04,  2, 1'b0, 1'b0, 12'h0, 32'h0};
    tbl[6]  = '{32'h2C000040, 0, 1'b0, 1'b0, 32'h100, 2, 1'b0, 1'b0, 12'h0, 32'h0};
    tbl[7]  = '{32'h03E00007, 0, 1'b0, 1'b0, 32'h08,  2, 1'b0, 1'b0, 12'h0, 32'h0};
    tbl[8]  = '{32'h18020000, 0, 1'b0, 1'b0, 32'h0C,  3, 1'b1, 1'b1, 12'h0, 32'h1};
    tbl[9]  = '{32'h18030000, 0, 1'b0, 1'b0, 32'h10,  3, 1'b1, 1'b1, 12'h0, 32'hFFFFFFFB};
    tbl[10] = '{32'h181F0000, 0, 1'b0, 1'b0, 32'h14,  3, 1'b1, 1'b1, 12'h0, 32'h8};
    tbl[11] = '{32'h14040005, 9, 1'b0, 1'b1, 32'h18,  8, 1'b1, 1'b0, 12'h5, 32'h0};
    tbl[12] = '{32'h18040000, 0, 1'b0, 1'b0, 32'h1C,  3, 1'b1, 1'b1, 12'h0, 32'h0};
    tbl[13] = '{32'hFC000000, 0, 1'b1, 1'b1, 32'h20,  2, 1'b0, 1'b0, 12'h0, 32'h0};
    tbl[14] = '{32'h00000008, 0, 1'b0, 1'b1, 32'h24,  2, 1'b0, 1'b0, 12'h0, 32'h0};
    tbl[15] = '{32'h181F0000, 0, 1'b0, 1'b0, 32'h28,  3, 1'b1, 1'b1, 12'h0, 32'h8};
    tbl[16] = '{32'h18050000, 0, 1'b0, 1'b0, 32'h2C,  3, 1'b1, 1'b1, 12'h0, 32'h0};
    tbl[17] = '{32'h18010007, 5, 1'b0, 1'b0, 32'h30,  8, 1'b1, 1'b1, 12'h7, 32'hFFFFFFFB};
    tbl[18] = '{32'h14060007, 0, 1'b0, 1'b0, 32'h34,  3, 1'b1, 1'b0, 12'h7, 32'h0};
    tbl[19] = '{32'h18060000, 0, 1'b0, 1'b0, 32'h38,  3, 1'b1, 1'b1, 12'h0, 32'hFFFFFFFB};

    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    for (int i = 0; i < 4096; i++) m_mem[i] = $urandom;
    m_pc = '0;

    bus.in_valid  = 1'b0;
    bus.inst      = '0;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;

    // Reset values.
    repeat (3) @(posedge clk);
    #1;
    check("rst.out_valid", 32'(bus.out_valid), 32'd0);
    check("rst.inst_addr", bus.inst_addr, 32'd0);
    check("rst.err",       32'(bus.err), 32'd0);
    check("rst.mem_req",   32'(bus.mem_req), 32'd0);
    check("rst.mem_port",  {19'd0, bus.mem_we, bus.mem_addr}, 32'd0);
    check("rst.mem_wdata", bus.mem_wdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Commit addi r5,r0,7 so PC and r5 are non-zero, then reset in EXEC of another.
    run_inst(32'h0C050007, 0, 1'b0, a);
    check("pre.pc", a.pc, 32'h4);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.inst     = 32'h0C070009;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rstexec.out_valid", 32'(bus.out_valid), 32'd0);
    check("rstexec.inst_addr", bus.inst_addr, 32'd0);
    check("rstexec.mem_req",   32'(bus.mem_req), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset while a load waits in MEM.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.inst     = 32'h14040005;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("rstmem.req_before", 32'(bus.mem_req), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rstmem.mem_req",  32'(bus.mem_req), 32'd0);
    check("rstmem.mem_addr", 32'(bus.mem_addr), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors from PC 0 with a cleared register file.
    for (int i = 0; i < 20; i++) begin
      exec_one(tbl[i].inst, tbl[i].d, tbl[i].pulse, a, x);
      t = x;
      t.err  = tbl[i].err;  t.pc   = tbl[i].pc;   t.lat = tbl[i].lat;
      t.mem  = tbl[i].mem;  t.we   = tbl[i].we;   t.addr = tbl[i].addr; t.wd = tbl[i].wd;
      t.reqc = tbl[i].mem ? ((tbl[i].d >= TMO) ? TMO : tbl[i].d + 1) : 0;
      t.stable = 1'b1; t.finished = 1'b1; t.single = 1'b1;
      cmp_obs($sformatf("vec%0d", i), a, t);
    end

    // Randomized instruction mix against the reference model.
    for (int n = 0; n < 300; n++) begin
      ins = $urandom;
      op  = 6'($urandom_range(0, 13));
      ins[31:26] = op;
      if (op == 6'd0) ins[5:0] = 6'($urandom_range(0, 9));
      d = $urandom_range(0, 8);
      p = ($urandom_range(0, 7) == 0);
      exec_one(ins, d, p, a, x);
      cmp_obs($sformatf("rnd%0d", n), a, x);
    end

    // Dump every register through the store port.
    for (int i = 0; i < 32; i++) begin
      ins = 32'h18000000 | (32'(i) << 16);
      exec_one(ins, $urandom_range(0, 3), 1'b0, a, x);
      cmp_obs($sformatf("dump_r%0d", i), a, x);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
